// File: rtl/llr_frame_loader.sv
// Turbo-decoder front end: buffers serial LLR triplets in a two-bank ping-pong
// store and presents each complete frame as parallel encoder-1/encoder-2 arrays.

module llr_lane #(
  parameter int BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [3:0][BITS-1:0] d,
  output logic [3:0][BITS-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (load) q <= d;
  end
endmodule

module llr_frame_loader #(
  parameter int BITS            = 32,
  parameter int SYMBOLS         = 10,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int P               = 3
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             s_valid,
  output logic                                             s_ready,
  input  logic [BITS-1:0]                                  s_sys,
  input  logic [BITS-1:0]                                  s_par1,
  input  logic [BITS-1:0]                                  s_par2,
  input  logic                                             s_last,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] encoder1_data_out,
  output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] encoder2_data_out,
  output logic                                             frame_error
);
  localparam int IW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

  if (BITS_PER_SYMBOL != 2) begin : g_bps_chk
    $error("llr_frame_loader: BITS_PER_SYMBOL must be 2");
  end
  if (SYMBOLS % P == 0) begin : g_p_chk
    $error("llr_frame_loader: P must not divide SYMBOLS");
  end

  typedef struct packed {
    logic [BITS-1:0] sys;
    logic [BITS-1:0] par1;
    logic [BITS-1:0] par2;
  } trip_t;

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

  trip_t          bank [2][SYMBOLS];
  logic           wp, rp;
  logic [IW-1:0]  wr_idx;
  logic [1:0]     full_cnt;
  state_t         state;
  logic           accept, at_end, commit, rel, load;

  assign s_ready = (full_cnt < 2'd2);
  assign accept  = s_valid && s_ready;
  assign at_end  = (wr_idx == IW'(SYMBOLS-1));
  assign commit  = accept && at_end;
  assign load    = (state == LOAD);
  assign rel     = load;

  // Storage carries no reset; validity is tracked entirely by wr_idx/full_cnt.
  always_ff @(posedge clk) begin
    if (accept) bank[wp][wr_idx] <= {s_sys, s_par1, s_par2};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp          <= 1'b0;
      wr_idx      <= '0;
      full_cnt    <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (accept) begin
        if (at_end) begin
          wr_idx      <= '0;
          wp          <= ~wp;
          frame_error <= ~s_last;
        end else if (s_last) begin
          wr_idx      <= '0;
          frame_error <= 1'b1;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
      case ({commit, rel})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rp        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (full_cnt != 2'd0) state <= LOAD;
        LOAD: begin
          rp        <= ~rp;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= (full_cnt != 2'd0) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane word order: 0 enc1 sys, 1 enc1 par, 2 enc2 sys (interleaved), 3 enc2 par.
  for (genvar j = 0; j < SYMBOLS; j++) begin : g_lane
    localparam int PJ = (P * j) % SYMBOLS;
    logic [3:0][BITS-1:0] d, q;
    assign d = {bank[rp][j].par2, bank[rp][PJ].sys, bank[rp][j].par1, bank[rp][j].sys};
    llr_lane #(.BITS(BITS)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .d       (d),
      .q       (q)
    );
    assign encoder1_data_out[0][j] = q[0];
    assign encoder1_data_out[1][j] = q[1];
    assign encoder2_data_out[0][j] = q[2];
    assign encoder2_data_out[1][j] = q[3];
  end
endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed bench for llr_frame_loader: expected frames go to a scoreboard queue
// when sent and are compared at each output handshake.

module tb_llr_frame_loader;
  localparam int BITS = 32, SYM = 10, BPS = 2, P = 3;
  typedef logic [BPS-1:0][SYM-1:0][BITS-1:0] arr_t;
  typedef struct { arr_t e1; arr_t e2; } frame_t;

  logic clk = 1'b0, reset_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, out_ready = 1'b0;
  logic [BITS-1:0] s_sys = '0, s_par1 = '0, s_par2 = '0;
  logic s_ready, out_valid, frame_error;
  arr_t e1, e2;

  frame_t sb[$];
  frame_t exf;
  int tests = 0, fails = 0, fe_cnt = 0;

  always #5 clk = ~clk;

  llr_frame_loader #(.BITS(BITS), .SYMBOLS(SYM), .BITS_PER_SYMBOL(BPS), .P(P)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_sys             (s_sys),
    .s_par1            (s_par1),
    .s_par2            (s_par2),
    .s_last            (s_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .encoder1_data_out (e1),
    .encoder2_data_out (e2),
    .frame_error       (frame_error)
  );

  function automatic logic [BITS-1:0] v(int k, int f, int j);
    return BITS'(k * 1000 + f + j);
  endfunction

  function automatic frame_t mk(int k);
    frame_t fr;
    for (int j = 0; j < SYM; j++) begin
      fr.e1[0][j] = v(k, 1, j);
      fr.e1[1][j] = v(k, 100, j);
      fr.e2[0][j] = v(k, 1, (P * j) % SYM);
      fr.e2[1][j] = v(k, 200, j);
    end
    return fr;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_arr(string tag, arr_t got, arr_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_trip(int k, int j, logic last);
    int guard = 0;
    s_valid = 1'b1; s_last = last;
    s_sys = v(k, 1, j); s_par1 = v(k, 100, j); s_par2 = v(k, 200, j);
    forever begin
      @(negedge clk);
      if (s_ready) break;
      guard++;
      if (guard > 500) begin
        tests++; fails++;
        $error("FAIL s_ready_timeout: observed s_ready=0 for %0d cycles expected 1", guard);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(int k, int early = -1, bit nolast = 1'b0);
    int n = (early >= 0) ? early + 1 : SYM;
    if (early < 0) sb.push_back(mk(k));
    for (int j = 0; j < n; j++)
      send_trip(k, j, (early >= 0) ? (j == early) : (!nolast && j == SYM - 1));
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 || out_valid) begin
      step(1);
      g++;
      if (g > 300) begin
        tests++; fails++;
        $error("FAIL drain_timeout: observed %0d frames pending expected 0", sb.size());
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $error("FAIL unexpected_frame: observed frame with e1[0][0]=%0h expected none", e1[0][0]);
      end else begin
        exf = sb.pop_front();
        chk_arr("frame_e1", e1, exf.e1);
        chk_arr("frame_e2", e2, exf.e2);
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arr_t zero, x1, x2;
    logic [BITS-1:0] tbl [SYM];
    int fe0;
    zero = '0;
    tbl = '{1, 4, 7, 10, 3, 6, 9, 2, 5, 8};

    // power-on reset
    step(3);
    chk("rst0_out_valid", out_valid, 0);
    chk("rst0_s_ready", s_ready, 1);
    reset_n = 1'b1;
    step(1);

    // mid-stream reset with one frame presented and a partial one in flight
    send_frame(4);
    for (int j = 0; j < 3; j++) send_trip(5, j, 1'b0);
    #2 reset_n = 1'b0;
    idle();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_frame_error", frame_error, 0);
    chk_arr("rst_e1_zero", e1, zero);
    chk_arr("rst_e2_zero", e2, zero);
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    step(1);
    out_ready = 1'b1;
    send_frame(6);
    idle();
    drain();

    // single frame: latency and mapping against literal tables
    out_ready = 1'b0;
    send_frame(0);
    idle();
    chk("lat_t0", out_valid, 0);
    step(1);
    chk("lat_t1", out_valid, 0);
    step(1);
    chk("lat_t2", out_valid, 1);
    for (int j = 0; j < SYM; j++) begin
      x1[0][j] = BITS'(j + 1);
      x1[1][j] = BITS'(100 + j);
      x2[0][j] = tbl[j];
      x2[1][j] = BITS'(200 + j);
    end
    chk_arr("map_e1", e1, x1);
    chk_arr("map_e2", e2, x2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk_arr("hold_e1", e1, x1);
    chk_arr("hold_e2", e2, x2);

    // backpressure: three frames while the consumer stalls
    send_frame(1);
    send_frame(2);
    send_frame(3);
    idle();
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_f1_presented", out_valid, 1);
    chk("bp_f1_word", e1[0][0], v(1, 1, 0));
    step(3);
    chk("bp_s_ready_hold", s_ready, 0);
    out_ready = 1'b1;
    @(negedge clk) chk("bp_v_f1", out_valid, 1);
    @(negedge clk) chk("bp_gap1", out_valid, 0);
    @(negedge clk) chk("bp_v_f2", out_valid, 1);
    chk("bp_s_ready_back", s_ready, 1);
    @(negedge clk) chk("bp_gap2", out_valid, 0);
    @(negedge clk) chk("bp_v_f3", out_valid, 1);
    @(negedge clk) chk("bp_idle", out_valid, 0);
    drain();

    // early s_last discards the partial frame
    fe0 = fe_cnt;
    send_frame(20, 4);
    idle();
    chk("early_fe_pulse", frame_error, 1);
    step(1);
    chk("early_fe_clear", frame_error, 0);
    step(4);
    chk("early_no_valid", out_valid, 0);
    chk("early_fe_count", fe_cnt - fe0, 1);
    send_frame(21);
    idle();
    drain();
    chk("good_no_fe", fe_cnt - fe0, 1);

    // missing s_last still commits
    fe0 = fe_cnt;
    send_frame(22, -1, 1'b1);
    idle();
    chk("nolast_fe_pulse", frame_error, 1);
    drain();
    chk("nolast_fe_count", fe_cnt - fe0, 1);

    // commit of frame 32 lands on the LOAD edge that releases frame 31's bank
    out_ready = 1'b0;
    send_frame(30);
    send_frame(31);
    sb.push_back(mk(32));
    for (int j = 0; j < SYM - 1; j++) send_trip(32, j, 1'b0);
    idle();
    chk("sim_f30_presented", out_valid, 1);
    out_ready = 1'b1;
    step(1);
    chk("sim_ready_pre", s_ready, 1);
    send_trip(32, SYM - 1, 1'b1);
    idle();
    chk("sim_ready_post", s_ready, 1);
    chk("sim_f31_presented", out_valid, 1);
    chk("sim_f31_word", e1[0][0], v(31, 1, 0));
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
